// File: rtl/sram_axi_bridge.sv
// rtl/sram_axi_bridge.sv - NCH sram-like request channels to one single-beat AXI3 master port
// Optional: SRAM_AXI_RAW_CHECK_EN (reads blocked only by a pending write to the same word)
module sram_axi_bridge #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int IDW = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NCH-1:0]     ch_req,
    input  logic [NCH-1:0]     ch_wr,
    input  logic [2*NCH-1:0]   ch_size,
    input  logic [AW*NCH-1:0]  ch_addr,
    input  logic [DW*NCH-1:0]  ch_wdata,
    output logic [NCH-1:0]     ch_addr_ok,
    output logic [NCH-1:0]     ch_data_ok,
    output logic [DW-1:0]      ch_rdata,
    output logic [IDW-1:0]     arid,
    output logic [AW-1:0]      araddr,
    output logic [2:0]         arsize,
    output logic               arvalid,
    input  logic               arready,
    input  logic [IDW-1:0]     rid,
    input  logic [DW-1:0]      rdata,
    input  logic               rvalid,
    output logic               rready,
    output logic [IDW-1:0]     awid,
    output logic [AW-1:0]      awaddr,
    output logic [2:0]         awsize,
    output logic               awvalid,
    input  logic               awready,
    output logic [DW-1:0]      wdata,
    output logic [DW/8-1:0]    wstrb,
    output logic               wvalid,
    input  logic               wready,
    input  logic [IDW-1:0]     bid,
    input  logic               bvalid,
    output logic               bready
);
    localparam int NB   = DW / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_WAIT} rstate_e;
    typedef enum logic [1:0] {W_IDLE, W_AWW, W_B} wstate_e;

    rstate_e          rstate_q, rstate_d;
    wstate_e          wstate_q, wstate_d;
    logic [AW-1:0]    araddr_q, araddr_d, awaddr_q, awaddr_d;
    logic [2:0]       arsize_q, arsize_d, awsize_q, awsize_d;
    logic [IDW-1:0]   arid_q, arid_d, awid_q, awid_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [NB-1:0]    wstrb_q, wstrb_d;
    logic             awvalid_q, awvalid_d, wvalid_q, wvalid_d;

    logic             rd_hit, wr_hit, rd_accept, wr_accept, rd_block, wr_pend;
    logic [IDW-1:0]   rd_win, wr_win;
    logic [AW-1:0]    rd_addr, wr_addr;
    logic [1:0]       rd_size, wr_size;
    logic [DW-1:0]    wr_wdata;

    function automatic logic [NB-1:0] strb_of(input logic [OFFW-1:0] off, input logic [1:0] sz);
        int n;
        int base;
        logic [NB-1:0] s;
        n    = 1 << sz;
        base = int'(off) & ~(n - 1);
        for (int i = 0; i < NB; i++) begin
            s[i] = (i >= base) && (i < base + n);
        end
        return s;
    endfunction

    // Fixed priority: the highest-indexed requester overwrites lower ones.
    always_comb begin
        rd_hit   = 1'b0;
        rd_win   = '0;
        rd_addr  = '0;
        rd_size  = '0;
        wr_hit   = 1'b0;
        wr_win   = '0;
        wr_addr  = '0;
        wr_size  = '0;
        wr_wdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_req[i] && !ch_wr[i]) begin
                rd_hit  = 1'b1;
                rd_win  = IDW'(i);
                rd_addr = ch_addr[i*AW +: AW];
                rd_size = ch_size[2*i +: 2];
            end
            if (ch_req[i] && ch_wr[i]) begin
                wr_hit   = 1'b1;
                wr_win   = IDW'(i);
                wr_addr  = ch_addr[i*AW +: AW];
                wr_size  = ch_size[2*i +: 2];
                wr_wdata = ch_wdata[i*DW +: DW];
            end
        end
    end

    assign wr_pend = (wstate_q != W_IDLE);
`ifdef SRAM_AXI_RAW_CHECK_EN
    assign rd_block = wr_pend && (rd_addr[AW-1:OFFW] == awaddr_q[AW-1:OFFW]);
`else
    assign rd_block = wr_pend;
`endif

    assign rd_accept = !reset && (rstate_q == R_IDLE) && rd_hit && !rd_block;
    assign wr_accept = !reset && (wstate_q == W_IDLE) && wr_hit;

    always_comb begin
        ch_addr_ok = '0;
        ch_data_ok = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_accept && rd_win == IDW'(i)) ch_addr_ok[i] = 1'b1;
            if (wr_accept && wr_win == IDW'(i)) ch_addr_ok[i] = 1'b1;
            if (rstate_q == R_WAIT && rvalid && rid == IDW'(i)) ch_data_ok[i] = 1'b1;
            if (wstate_q == W_B && bvalid && bid == IDW'(i)) ch_data_ok[i] = 1'b1;
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        araddr_d = araddr_q;
        arsize_d = arsize_q;
        arid_d   = arid_q;
        case (rstate_q)
            R_IDLE: if (rd_accept) begin
                rstate_d = R_AR;
                araddr_d = rd_addr;
                arsize_d = {1'b0, rd_size};
                arid_d   = rd_win;
            end
            R_AR:    if (arready) rstate_d = R_WAIT;
            R_WAIT:  if (rvalid)  rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    // AW and W retire independently; the FSM moves on once both have handshaken.
    always_comb begin
        wstate_d  = wstate_q;
        awaddr_d  = awaddr_q;
        awsize_d  = awsize_q;
        awid_d    = awid_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        case (wstate_q)
            W_IDLE: if (wr_accept) begin
                wstate_d  = W_AWW;
                awaddr_d  = wr_addr;
                awsize_d  = {1'b0, wr_size};
                awid_d    = wr_win;
                wdata_d   = wr_wdata;
                wstrb_d   = strb_of(wr_addr[OFFW-1:0], wr_size);
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
            end
            W_AWW: begin
                if (awvalid_q && awready) awvalid_d = 1'b0;
                if (wvalid_q && wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) wstate_d = W_B;
            end
            W_B:     if (bvalid) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstate_q  <= R_IDLE;
            wstate_q  <= W_IDLE;
            araddr_q  <= '0;
            arsize_q  <= '0;
            arid_q    <= '0;
            awaddr_q  <= '0;
            awsize_q  <= '0;
            awid_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
        end else begin
            rstate_q  <= rstate_d;
            wstate_q  <= wstate_d;
            araddr_q  <= araddr_d;
            arsize_q  <= arsize_d;
            arid_q    <= arid_d;
            awaddr_q  <= awaddr_d;
            awsize_q  <= awsize_d;
            awid_q    <= awid_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
        end
    end

    assign arvalid  = (rstate_q == R_AR);
    assign rready   = (rstate_q == R_WAIT);
    assign bready   = (wstate_q == W_B);
    assign araddr   = araddr_q;
    assign arsize   = arsize_q;
    assign arid     = arid_q;
    assign awaddr   = awaddr_q;
    assign awsize   = awsize_q;
    assign awid     = awid_q;
    assign awvalid  = awvalid_q;
    assign wvalid   = wvalid_q;
    assign wdata    = wdata_q;
    assign wstrb    = wstrb_q;
    assign ch_rdata = rdata;
endmodule
